instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Sequences instruction fetch from the byte-wide instruction memory into the opcode/data demux register pair.
- Steps through an opcode byte and a data byte per instruction, then presents the instruction to decode with a valid/ready handshake.
- Owns the program counter (PC), the memory address, the demux select line and the demux synchronous clear, and applies branch targets supplied by decode.

Parameters:
- ADDR_W, 8, instruction memory address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value after reset; must be even.
- HALT_OPCODE, 8'hFF, opcode value recognised by the optional halt detect.

Ports:
- instr_fetch_ctrl_clk  in  1  single clock, rising edge.
- instr_fetch_ctrl_rst  in  1  asynchronous reset, active-low.
- instr_fetch_ctrl_start  in  1  begin or resume fetching; honoured only in IDLE or HALTED.
- instr_fetch_ctrl_halt_req  in  1  stop at the next instruction boundary.
- instr_fetch_ctrl_ready  in  1  decode accepts the presented instruction.
- instr_fetch_ctrl_branch_en  in  1  branch qualifier, sampled only on handshake.
- instr_fetch_ctrl_branch_target  in  ADDR_W  branch address; bit 0 is ignored and forced to 0.
- instr_fetch_ctrl_opcode  in  8  opcode register output from the demux (used only by the optional halt detect).
- instr_fetch_ctrl_mem_addr  out  ADDR_W  instruction memory read address; memory read is combinational.
- instr_fetch_ctrl_demux_select  out  1  1 = demux captures opcode, 0 = demux captures data.
- instr_fetch_ctrl_demux_rst  out  1  active-high synchronous clear to the demux.
- instr_fetch_ctrl_valid  out  1  instruction is presented to decode.
- instr_fetch_ctrl_pc  out  ADDR_W  address of the current instruction's opcode byte.
- instr_fetch_ctrl_halted  out  1  controller is in HALTED.
- instr_fetch_ctrl_instr_count  out  16  count of issued instructions; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, PC = RESET_PC, instr_count = 0.
  - Outputs: mem_addr = RESET_PC, demux_select = 0, demux_rst = 1, valid = 0, halted = 0.
- All outputs are Moore outputs, decoded from state and PC only.
- The demux writes one of its two registers on every clock edge. The controller therefore never leaves select = 1 outside FETCH_OP, so the opcode register holds its value.
- IDLE:
  - Outputs: addr = PC, select = 0, demux_rst = 1.
  - start -> FETCH_OP.
- FETCH_OP:
  - Outputs: addr = PC, select = 1; the opcode is latched at the exiting edge.
  - Always -> FETCH_DATA.
- FETCH_DATA:
  - Outputs: addr = PC+1, select = 0; the data byte is latched.
  - Always -> ISSUE.
- ISSUE:
  - Outputs: addr = PC+1, select = 0 (data register rewrites the same byte, so it stays stable), valid = 1.
  - valid stays high until ready is sampled high.
  - On handshake (valid & ready):
    - instr_count increments.
    - PC becomes {branch_target[ADDR_W-1:1], 0} if branch_en is high, otherwise PC+2 (mod 2^ADDR_W).
    - If halt_req is high -> HALTED, otherwise -> FETCH_OP.
- HALTED:
  - Outputs: addr = PC, select = 0, valid = 0, halted = 1, demux_rst = 0 (last instruction registers are kept).
  - start -> FETCH_OP using the PC already updated at the last handshake.
- Latency:
  - From start sampled in IDLE to valid high: 3 cycles.
  - Back-to-back with ready held high: one instruction per 3 cycles.
- Boundary conditions:
  - PC = 2^ADDR_W-2: the data byte address is 2^ADDR_W-1 and the next PC wraps to 0.
  - branch_en and halt_req on the same handshake: the branch is applied, then HALTED.
  - halt_req outside a handshake has no effect; it must be held until the handshake.
  - start in FETCH_OP, FETCH_DATA or ISSUE is ignored.
  - Reset asserted mid-fetch returns immediately to the reset values, with no partial instruction issued.

Optional Feature:
- INSTR_FETCH_CTRL_HALT_DETECT_EN
  - Defined: on handshake, if opcode == HALT_OPCODE, the controller enters HALTED exactly as if halt_req were high. PC still advances (or branches) normally.
  - Undefined: the opcode input is unused and only halt_req halts.

Test Plan:
- Reset, then start pulse with RESET_PC = 0 and ready = 1 -> mem_addr sequence 0,1,1,2,3,3; valid high in cycles 3 and 6; instr_count = 2.
- ready held low for 4 cycles in ISSUE -> valid stays 1, addr stays PC+1, select stays 0, PC unchanged; single count increment once ready rises.
- Branch on handshake with branch_target = 8'h35 -> next FETCH_OP addr = 8'h34, data addr = 8'h35.
- PC = 8'hFE -> data addr 8'hFF; next FETCH_OP addr 8'h00.
- halt_req together with branch_target = 8'h10 on handshake -> halted = 1, valid = 0; after start, fetch resumes at 8'h10.
- Reset asserted during FETCH_DATA -> all outputs return to reset values within the same cycle, demux_rst = 1, no valid pulse.
- With INSTR_FETCH_CTRL_HALT_DETECT_EN defined, opcode 8'hFF issued -> halted after that handshake.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller.
// Fetches an opcode byte and a data byte from byte-wide instruction memory into
// the opcode/data demux, then presents the instruction to decode with valid/ready.
// Owns the PC, the memory address, the demux select and the demux clear.
// Optional halt-on-opcode detect is enabled by defining INSTR_FETCH_CTRL_HALT_DETECT_EN.
module instr_fetch_ctrl #(
   parameter int unsigned       ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
   input  logic              instr_fetch_ctrl_clk,
   input  logic              instr_fetch_ctrl_rst,
   input  logic              instr_fetch_ctrl_start,
   input  logic              instr_fetch_ctrl_halt_req,
   input  logic              instr_fetch_ctrl_ready,
   input  logic              instr_fetch_ctrl_branch_en,
   input  logic [ADDR_W-1:0] instr_fetch_ctrl_branch_target,
   input  logic [7:0]        instr_fetch_ctrl_opcode,
   output logic [ADDR_W-1:0] instr_fetch_ctrl_mem_addr,
   output logic              instr_fetch_ctrl_demux_select,
   output logic              instr_fetch_ctrl_demux_rst,
   output logic              instr_fetch_ctrl_valid,
   output logic [ADDR_W-1:0] instr_fetch_ctrl_pc,
   output logic              instr_fetch_ctrl_halted,
   output logic [15:0]       instr_fetch_ctrl_instr_count
);

   typedef enum logic [2:0] {
      StIdle,
      StFetchOp,
      StFetchData,
      StIssue,
      StHalted
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       count_q, count_d;
   logic [ADDR_W-1:0] pc_plus1, pc_plus2;
   logic              handshake;
   logic              halt_now;

   assign pc_plus1  = pc_q + ADDR_W'(1);
   assign pc_plus2  = pc_q + ADDR_W'(2);
   assign handshake = (state_q == StIssue) && instr_fetch_ctrl_ready;

`ifdef INSTR_FETCH_CTRL_HALT_DETECT_EN
   // Opcode register is stable through ISSUE, so it can be compared at the handshake.
   assign halt_now = instr_fetch_ctrl_halt_req || (instr_fetch_ctrl_opcode == HALT_OPCODE);
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = instr_fetch_ctrl_branch_target[0];
`else
   assign halt_now = instr_fetch_ctrl_halt_req;
   logic unused_inputs;
   assign unused_inputs = ^{instr_fetch_ctrl_opcode, instr_fetch_ctrl_branch_target[0],
                            HALT_OPCODE};
`endif

   // State, PC and instruction counter registers.
   always_ff @(posedge instr_fetch_ctrl_clk or negedge instr_fetch_ctrl_rst) begin
      if (!instr_fetch_ctrl_rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   // Next-state, PC update and counter update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (instr_fetch_ctrl_start) state_d = StFetchOp;
         end
         StFetchOp:   state_d = StFetchData;
         StFetchData: state_d = StIssue;
         StIssue: begin
            if (handshake) begin
               count_d = count_q + 16'd1;
               pc_d    = instr_fetch_ctrl_branch_en ?
                         {instr_fetch_ctrl_branch_target[ADDR_W-1:1], 1'b0} : pc_plus2;
               state_d = halt_now ? StHalted : StFetchOp;
            end
         end
         StHalted: begin
            if (instr_fetch_ctrl_start) state_d = StFetchOp;
         end
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs; select is high only in FETCH_OP so the opcode register holds otherwise.
   always_comb begin
      instr_fetch_ctrl_mem_addr     = pc_q;
      instr_fetch_ctrl_demux_select = 1'b0;
      instr_fetch_ctrl_demux_rst    = 1'b0;
      instr_fetch_ctrl_valid        = 1'b0;
      instr_fetch_ctrl_halted       = 1'b0;
      unique case (state_q)
         StIdle:      instr_fetch_ctrl_demux_rst = 1'b1;
         StFetchOp:   instr_fetch_ctrl_demux_select = 1'b1;
         StFetchData: instr_fetch_ctrl_mem_addr = pc_plus1;
         StIssue: begin
            instr_fetch_ctrl_mem_addr = pc_plus1;
            instr_fetch_ctrl_valid    = 1'b1;
         end
         StHalted:    instr_fetch_ctrl_halted = 1'b1;
         default:     instr_fetch_ctrl_demux_rst = 1'b1;
      endcase
   end

   assign instr_fetch_ctrl_pc          = pc_q;
   assign instr_fetch_ctrl_instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl (ADDR_W = 8, RESET_PC = 0).
// Each queue entry holds the inputs applied before a rising edge and the outputs
// expected after it, sampled on the following falling edge.
module tb_instr_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start, halt_req, ready, branch_en;
   logic [7:0]  branch_target, opcode;
   logic [7:0]  mem_addr, pc;
   logic        demux_select, demux_rst, valid, halted;
   logic [15:0] instr_count;

   typedef struct packed {
      logic       start;
      logic       halt;
      logic       ready;
      logic       br_en;
      logic [7:0] tgt;
   } stim_t;

   typedef struct packed {
      logic [7:0]  addr;
      logic        sel;
      logic        drst;
      logic        valid;
      logic        halted;
      logic [7:0]  pc;
      logic [15:0] cnt;
   } obs_t;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   int    vectors = 0;
   int    misses  = 0;

   instr_fetch_ctrl dut (
      .instr_fetch_ctrl_clk           (clk),
      .instr_fetch_ctrl_rst           (rst_n),
      .instr_fetch_ctrl_start         (start),
      .instr_fetch_ctrl_halt_req      (halt_req),
      .instr_fetch_ctrl_ready         (ready),
      .instr_fetch_ctrl_branch_en     (branch_en),
      .instr_fetch_ctrl_branch_target (branch_target),
      .instr_fetch_ctrl_opcode        (opcode),
      .instr_fetch_ctrl_mem_addr      (mem_addr),
      .instr_fetch_ctrl_demux_select  (demux_select),
      .instr_fetch_ctrl_demux_rst     (demux_rst),
      .instr_fetch_ctrl_valid         (valid),
      .instr_fetch_ctrl_pc            (pc),
      .instr_fetch_ctrl_halted        (halted),
      .instr_fetch_ctrl_instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void push(input logic s, input logic h, input logic r, input logic b,
                                input logic [7:0] t, input logic [7:0] a, input logic sel,
                                input logic dr, input logic v, input logic hl,
                                input logic [7:0] p, input logic [15:0] c);
      stim_q.push_back({s, h, r, b, t});
      exp_q.push_back({a, sel, dr, v, hl, p, c});
   endfunction

   task automatic test_reset();
      obs_t o;
      rst_n = 1'b0;
      {start, halt_req, ready, branch_en, branch_target, opcode} = '0;
      @(negedge clk);
      o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
      vectors++;
      if (o !== obs_t'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0})) begin
         misses++;
         $display("FAIL reset_state: got %h want %h", o,
                  obs_t'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0}));
      end
      rst_n = 1'b1;
      // idle without start stays idle
      push(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 16'd0);
      push(0, 1, 1, 1, 8'h22, 8'h00, 0, 1, 0, 0, 8'h00, 16'd0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL reset_idle step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      push(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h02, 1, 0, 0, 0, 8'h02, 16'd1);
      push(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 0, 0, 8'h02, 16'd1);
      push(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 1, 0, 8'h02, 16'd1);
      push(0, 1, 1, 0, 8'h00, 8'h04, 0, 0, 0, 1, 8'h04, 16'd2);
      push(0, 0, 0, 0, 8'h00, 8'h04, 0, 0, 0, 1, 8'h04, 16'd2);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL back_to_back step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_stall();
      obs_t o;
      push(1, 0, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 8'h04, 16'd2);
      push(0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0, 0, 8'h04, 16'd2);
      push(0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 1, 0, 8'h04, 16'd2);
      // ready low for 4 cycles; start and a stray halt pulse must be ignored
      push(1, 1, 0, 1, 8'h40, 8'h05, 0, 0, 1, 0, 8'h04, 16'd2);
      push(1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 1, 0, 8'h04, 16'd2);
      push(1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 1, 0, 8'h04, 16'd2);
      push(1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 1, 0, 8'h04, 16'd2);
      push(0, 1, 1, 0, 8'h00, 8'h06, 0, 0, 0, 1, 8'h06, 16'd3);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL stall step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_branch_wrap();
      obs_t o;
      push(1, 0, 0, 0, 8'h00, 8'h06, 1, 0, 0, 0, 8'h06, 16'd3);
      push(0, 0, 1, 1, 8'h80, 8'h07, 0, 0, 0, 0, 8'h06, 16'd3);
      push(0, 0, 0, 0, 8'h00, 8'h07, 0, 0, 1, 0, 8'h06, 16'd3);
      // branch target bit 0 is dropped
      push(0, 0, 1, 1, 8'h35, 8'h34, 1, 0, 0, 0, 8'h34, 16'd4);
      push(0, 0, 0, 0, 8'h00, 8'h35, 0, 0, 0, 0, 8'h34, 16'd4);
      push(0, 0, 0, 0, 8'h00, 8'h35, 0, 0, 1, 0, 8'h34, 16'd4);
      push(0, 0, 1, 1, 8'hFE, 8'hFE, 1, 0, 0, 0, 8'hFE, 16'd5);
      push(0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0, 0, 8'hFE, 16'd5);
      push(0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 1, 0, 8'hFE, 16'd5);
      // PC+2 wraps from FE to 00
      push(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 16'd6);
      push(0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 8'h00, 16'd6);
      push(0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00, 16'd6);
      push(0, 1, 1, 0, 8'h00, 8'h02, 0, 0, 0, 1, 8'h02, 16'd7);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL branch_wrap step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_halt_branch();
      obs_t o;
      push(1, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 8'h02, 16'd7);
      push(0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, 0, 8'h02, 16'd7);
      push(0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 1, 0, 8'h02, 16'd7);
      push(0, 1, 1, 1, 8'h10, 8'h10, 0, 0, 0, 1, 8'h10, 16'd8);
      push(0, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0, 1, 8'h10, 16'd8);
      push(1, 0, 0, 0, 8'h00, 8'h10, 1, 0, 0, 0, 8'h10, 16'd8);
      push(0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0, 0, 8'h10, 16'd8);
      push(0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 1, 0, 8'h10, 16'd8);
      push(0, 0, 1, 0, 8'h00, 8'h12, 1, 0, 0, 0, 8'h12, 16'd9);
      push(0, 0, 0, 0, 8'h00, 8'h13, 0, 0, 0, 0, 8'h12, 16'd9);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL halt_branch step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   // Entered while in FETCH_DATA.
   task automatic test_reset_mid();
      obs_t o;
      obs_t rst_val;
      rst_val = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
      start = 1'b1;
      ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
      vectors++;
      if (o !== rst_val) begin
         misses++;
         $display("FAIL reset_mid_async: got %h want %h", o, rst_val);
      end
      repeat (2) @(negedge clk);
      o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
      vectors++;
      if (o !== rst_val) begin
         misses++;
         $display("FAIL reset_mid_held: got %h want %h", o, rst_val);
      end
      rst_n = 1'b1;
      push(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 16'd0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL reset_mid_idle step %0d: got %h want %h", k, o, e);
         end
      end
   endtask

   // Opcode FF halts only when the detect is built in.
   task automatic test_halt_opcode();
      obs_t o;
      opcode = 8'hFF;
      push(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0, 0, 8'h00, 16'd0);
      push(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00, 16'd0);
`ifdef INSTR_FETCH_CTRL_HALT_DETECT_EN
      push(0, 0, 1, 0, 8'h00, 8'h02, 0, 0, 0, 1, 8'h02, 16'd1);
`else
      push(0, 0, 1, 0, 8'h00, 8'h02, 1, 0, 0, 0, 8'h02, 16'd1);
      push(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 0, 0, 8'h02, 16'd1);
      push(0, 0, 1, 0, 8'h00, 8'h03, 0, 0, 1, 0, 8'h02, 16'd1);
      push(0, 1, 1, 0, 8'h00, 8'h04, 0, 0, 0, 1, 8'h04, 16'd2);
`endif
      for (int k = 0; stim_q.size() != 0; k++) begin
         stim_t s = stim_q.pop_front();
         obs_t  e = exp_q.pop_front();
         {start, halt_req, ready, branch_en, branch_target} = s;
         @(negedge clk);
         o = {mem_addr, demux_select, demux_rst, valid, halted, pc, instr_count};
         vectors++;
         if (o !== e) begin
            misses++;
            $display("FAIL halt_opcode step %0d: got %h want %h", k, o, e);
         end
      end
      opcode = 8'h00;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_branch_wrap();
      test_halt_branch();
      test_reset_mid();
      test_halt_opcode();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
